// File: rtl/upsample_writeback_if.sv
// Bus bundle for the 2x nearest-neighbour upsample writeback stage:
// layer control, conv pixel stream, OFM RAM write port and status.
interface upsample_writeback_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20
);
  // Control / configuration (sampled only on an accepted start)
  logic                    start;
  logic [8:0]              ofm_size_conv;
  logic [10:0]             num_channel;
  logic [ADDR_WIDTH-1:0]   base_addr;

  // Pixel stream: a beat transfers on a rising edge where in_valid && in_ready.
  // The producer holds in_valid and in_data stable until that edge; in_ready is
  // registered and never depends combinationally on in_valid.
  logic                    in_valid;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_ready;

  // OFM RAM double-element write port and status
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [2*DATA_WIDTH-1:0] wr_data;
  logic                    busy;
  logic                    done;
  logic [1:0]              fsm_state;

  modport master (
    output start, ofm_size_conv, num_channel, base_addr, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, fsm_state
  );

  modport slave (
    input  start, ofm_size_conv, num_channel, base_addr, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, fsm_state
  );
endinterface

// File: rtl/upsample_writeback.sv
// Nearest-neighbour 2x upsample: each conv pixel becomes a 2x2 block in OFM RAM,
// written as a top-row pair then a bottom-row pair (two double-element writes).
module upsample_writeback #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  upsample_writeback_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TOP  = 2'd1,
    BOT  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t                  state;
  logic [8:0]              size_q;
  logic [10:0]             chan_q;
  logic [ADDR_WIDTH-1:0]   two_s;
  logic [ADDR_WIDTH-1:0]   top_addr;
  logic [8:0]              col;
  logic [8:0]              row;
  logic [10:0]             ch;
  logic [DATA_WIDTH-1:0]   pix;
  logic                    last_col;
  logic                    last_row;
  logic                    last_ch;

  assign last_col      = (col == size_q - 9'd1);
  assign last_row      = (row == size_q - 9'd1);
  assign last_ch       = (ch == chan_q - 11'd1);
  assign bus.fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      size_q       <= '0;
      chan_q       <= '0;
      two_s        <= '0;
      top_addr     <= '0;
      col          <= '0;
      row          <= '0;
      ch           <= '0;
      pix          <= '0;
      bus.in_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      bus.done  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            size_q   <= bus.ofm_size_conv;
            chan_q   <= bus.num_channel;
            two_s    <= ADDR_WIDTH'({bus.ofm_size_conv, 1'b0});
            top_addr <= bus.base_addr;
            col      <= '0;
            row      <= '0;
            ch       <= '0;
            bus.busy <= 1'b1;
            if (bus.ofm_size_conv == 9'd0 || bus.num_channel == 11'd0) begin
              state <= FIN;
            end else begin
              state        <= TOP;
              bus.in_ready <= 1'b1;
            end
          end
        end
        TOP: begin
          if (bus.in_valid) begin
            pix          <= bus.in_data;
            bus.wr_en    <= 1'b1;
            bus.wr_addr  <= top_addr;
            bus.wr_data  <= {bus.in_data, bus.in_data};
            bus.in_ready <= 1'b0;
            state        <= BOT;
          end
        end
        BOT: begin
          bus.wr_en   <= 1'b1;
          bus.wr_addr <= top_addr + two_s;
          bus.wr_data <= {pix, pix};
          // End of a conv row: also hop over the odd output row just filled.
          if (last_col) begin
            top_addr <= top_addr + two_s + ADDR_WIDTH'(2);
            col      <= '0;
            if (last_row) begin
              row <= '0;
              ch  <= ch + 11'd1;
            end else begin
              row <= row + 9'd1;
            end
          end else begin
            top_addr <= top_addr + ADDR_WIDTH'(2);
            col      <= col + 9'd1;
          end
          if (last_col && last_row && last_ch) begin
            state <= FIN;
          end else begin
            state        <= TOP;
            bus.in_ready <= 1'b1;
          end
        end
        FIN: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_upsample_writeback.sv
// Bench for upsample_writeback: an index-arithmetic model of the 2x2 block layout
// feeds an expected write queue; a sink RAM image is checked against the NN model.
module tb_upsample_writeback;

  localparam int DW = 16;
  localparam int AW = 20;
  localparam int RAM_N = 131072;

  logic clk = 1'b0;
  logic rst;

  upsample_writeback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  upsample_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [AW+2*DW-1:0] exp_q[$];
  logic [AW-1:0]      wlog_addr[$];
  logic [2*DW-1:0]    wlog_data[$];
  logic [DW-1:0]      ram [0:RAM_N-1];
  logic [DW-1:0]      gold [0:71];
  logic [DW-1:0]      pix[];
  bit                 layer_active = 0;
  bit                 layer_nonempty = 0;
  int                 writes_seen = 0;
  int                 done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected write sequence derived from output-pixel coordinates.
  task automatic build_model(input int s, input int c, input int base);
    exp_q.delete();
    for (int k = 0; k < c; k++)
      for (int r = 0; r < s; r++)
        for (int x = 0; x < s; x++) begin
          logic [DW-1:0] p;
          int a_top;
          int a_bot;
          logic [AW-1:0] at;
          logic [AW-1:0] ab;
          p     = pix[(k * s + r) * s + x];
          a_top = base + k * 4 * s * s + (2 * r) * (2 * s) + 2 * x;
          a_bot = a_top + 2 * s;
          at    = a_top[AW-1:0];
          ab    = a_bot[AW-1:0];
          exp_q.push_back({at, p, p});
          exp_q.push_back({ab, p, p});
        end
  endtask

  // Compare process
  initial begin
    bit prev_acc = 0;
    bit prev2_acc = 0;
    bit prev_wr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_acc = 0; prev2_acc = 0; prev_wr = 0;
      end else begin
        if (prev_acc) begin
          chk("top_write_latency", bus.wr_en, 1);
          chk("ready_low_after_accept", bus.in_ready, 0);
        end
        if (prev2_acc) chk("bot_write_latency", bus.wr_en, 1);
        if (bus.wr_en) begin
          int ai;
          writes_seen++;
          wlog_addr.push_back(bus.wr_addr);
          wlog_data.push_back(bus.wr_data);
          ai = int'(bus.wr_addr);
          if (ai + 1 < RAM_N) begin
            ram[ai]     = bus.wr_data[DW-1:0];
            ram[ai + 1] = bus.wr_data[2*DW-1:DW];
          end
          if (exp_q.size() == 0) chk("unexpected_write", {bus.wr_addr, bus.wr_data}, 0);
          else chk("write", {bus.wr_addr, bus.wr_data}, exp_q.pop_front());
        end
        if (bus.done) begin
          done_cnt++;
          chk("done_expected", layer_active, 1);
          chk("done_queue_drained", exp_q.size(), 0);
          chk("done_after_last_write", prev_wr, layer_nonempty);
          chk("busy_low_at_done", bus.busy, 0);
          layer_active = 0;
        end
        prev2_acc = prev_acc;
        prev_acc  = bus.in_ready & bus.in_valid;
        prev_wr   = bus.wr_en;
      end
    end
  end

  // Driver tasks: all enter and leave just after a rising edge.
  task automatic pulse_start(input int s, input int c, input int base);
    bus.ofm_size_conv = s[8:0];
    bus.num_channel   = c[10:0];
    bus.base_addr     = base[AW-1:0];
    bus.start         = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_pixel(input logic [DW-1:0] d, input bit gap);
    int n;
    n = 0;
    if (gap) while ($urandom_range(0, 1) == 1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.done && cycles < 200);
    if (!bus.done) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_layer(input int s, input int c, input int base, input bit gap,
                           output int cycles);
    int w0;
    build_model(s, c, base);
    layer_active   = 1;
    layer_nonempty = (s != 0 && c != 0);
    w0 = writes_seen;
    pulse_start(s, c, base);
    chk("busy_after_start", bus.busy, 1);
    for (int i = 0; i < s * s * c; i++) send_pixel(pix[i], gap);
    wait_done(cycles);
    chk("write_count", writes_seen - w0, 2 * s * s * c);
  endtask

  task automatic check_image(input int s, input int c, input int base);
    for (int k = 0; k < c; k++)
      for (int y = 0; y < 2 * s; y++)
        for (int x = 0; x < 2 * s; x++)
          chk("nn_image", ram[base + k * 4 * s * s + y * 2 * s + x],
              pix[(k * s + y / 2) * s + x / 2]);
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int cyc;
    int d0;
    logic [AW-1:0] s2_addr [8];
    logic [DW-1:0] s2_val [8];
    logic [DW-1:0] s2_img [16];
    s2_addr = '{100, 104, 102, 106, 108, 112, 110, 114};
    s2_val  = '{1, 1, 2, 2, 3, 3, 4, 4};
    s2_img  = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};

    rst = 1'b1;
    bus.start = 1'b0; bus.ofm_size_conv = '0; bus.num_channel = '0;
    bus.base_addr = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_state", bus.fsm_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // S=1, C=1: one pixel, two writes
    pix = new[1];
    pix[0] = 16'h0005;
    wlog_addr.delete(); wlog_data.delete();
    run_layer(1, 1, 16, 0, cyc);
    chk("s1_nwrites", wlog_addr.size(), 2);
    chk("s1_addr0", wlog_addr[0], 16);
    chk("s1_data0", wlog_data[0], 32'h00050005);
    chk("s1_addr1", wlog_addr[1], 18);
    chk("s1_data1", wlog_data[1], 32'h00050005);

    // S=2, C=1, base 100, pixels 1..4
    pix = new[4];
    for (int i = 0; i < 4; i++) pix[i] = DW'(i + 1);
    wlog_addr.delete(); wlog_data.delete();
    run_layer(2, 1, 100, 0, cyc);
    chk("s2_nwrites", wlog_addr.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("s2_addr", wlog_addr[i], s2_addr[i]);
      chk("s2_data", wlog_data[i], {s2_val[i], s2_val[i]});
    end
    for (int i = 0; i < 16; i++) chk("s2_ram_row", ram[100 + i], s2_img[i]);

    // C=0: done with zero writes
    wlog_addr.delete(); wlog_data.delete();
    run_layer(3, 0, 40, 0, cyc);
    chk("c0_nwrites", wlog_addr.size(), 0);
    chk("c0_done_latency", cyc, 2);

    // Second start mid-layer (with altered config) is ignored
    pix = new[4];
    pix[0] = 16'h0009; pix[1] = 16'h0008; pix[2] = 16'h0007; pix[3] = 16'h0006;
    build_model(2, 1, 200);
    layer_active = 1; layer_nonempty = 1;
    d0 = writes_seen;
    pulse_start(2, 1, 200);
    send_pixel(pix[0], 0);
    send_pixel(pix[1], 0);
    pulse_start(5, 3, 500);
    send_pixel(pix[2], 0);
    send_pixel(pix[3], 0);
    wait_done(cyc);
    chk("midstart_write_count", writes_seen - d0, 8);
    check_image(2, 1, 200);

    // S=3, C=2 gap-free, then the same pixels with random valid gaps
    pix = new[18];
    for (int i = 0; i < 18; i++) pix[i] = DW'($urandom_range(0, 65535));
    run_layer(3, 2, 7, 0, cyc);
    for (int i = 0; i < 72; i++) gold[i] = ram[7 + i];
    for (int i = 0; i < 72; i++) ram[7 + i] = 'x;
    run_layer(3, 2, 7, 1, cyc);
    for (int i = 0; i < 72; i++) chk("gap_image", ram[7 + i], gold[i]);
    check_image(3, 2, 7);

    // Reset after 5 of 9 pixels aborts the layer
    pix = new[9];
    for (int i = 0; i < 9; i++) pix[i] = DW'(16'h0100 + i);
    build_model(3, 1, 300);
    layer_active = 1; layer_nonempty = 1;
    pulse_start(3, 1, 300);
    for (int i = 0; i < 5; i++) send_pixel(pix[i], 0);
    @(negedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    layer_active = 0;
    @(negedge clk);
    chk("abort_wr_en", bus.wr_en, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    chk("abort_state", bus.fsm_state, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    d0 = done_cnt;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, d0);
    chk("abort_idle_busy", bus.busy, 0);
    run_layer(3, 1, 300, 0, cyc);
    check_image(3, 1, 300);

    // Full-size layer: S=13, C=128
    pix = new[13 * 13 * 128];
    for (int i = 0; i < 13 * 13 * 128; i++) pix[i] = DW'($urandom_range(0, 65535));
    run_layer(13, 128, 0, 0, cyc);
    check_image(13, 128, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
